// File: rtl/port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : port_arbiter_if
//  Purpose  : Bundle of the requester-side and downstream-side signals of the
//             round-robin port arbiter.
//  Ports    : req_data    - NUM_REQ packets, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//             req_valid   - per-requester valid
//             req_ready   - per-requester accept (combinational)
//             out_data    - registered output packet
//             out_valid   - out_data holds a packet
//             out_ready   - downstream accepts out_data
//             grant_id    - index of the requester whose packet is held
//             grant_count - accepted-packet counter (zero unless enabled)
//  Modports : master - requesters plus downstream consumer
//             slave  - the arbiter
//  Revision : 1.0 - initial release
// ============================================================================
interface port_arbiter_if #(
    parameter int NUM_REQ    = 5,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [2:0]                    grant_id;
    logic [15:0]                   grant_count;

    modport master (
        output req_data,
        output req_valid,
        output out_ready,
        input  req_ready,
        input  out_data,
        input  out_valid,
        input  grant_id,
        input  grant_count
    );

    modport slave (
        input  req_data,
        input  req_valid,
        input  out_ready,
        output req_ready,
        output out_data,
        output out_valid,
        output grant_id,
        output grant_count
    );
endinterface
`default_nettype wire

// File: rtl/port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : port_arbiter
//  Purpose  : Round-robin arbiter feeding a one-entry output register.
//             Each free cycle one valid requester is granted, searching from
//             the index after the last winner. The granted packet appears on
//             out_data one cycle later together with its requester index.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - port_arbiter_if.slave (see interface for signal list)
//  Options  : PORT_ARB_GRANT_CNT_EN - when defined, grant_count counts
//             accepted packets (16-bit, wrapping); otherwise it is tied to 0.
//  Notes    : NUM_REQ must be in 2..8 so the winner index fits grant_id.
//             The interface instance must use the same NUM_REQ/DATA_WIDTH.
//  Revision : 1.0 - initial release
// ============================================================================
module port_arbiter #(
    parameter int NUM_REQ    = 5,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    port_arbiter_if.slave   bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // Reset value of last winner makes the very first search start at index 0.
    localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                state_q,       state_d;
    logic [DATA_WIDTH-1:0] out_data_q,    out_data_d;
    logic [2:0]            grant_id_q,    grant_id_d;
    logic [IDX_W-1:0]      last_winner_q, last_winner_d;

    logic                  w_free;
    logic                  w_transfer;
    logic [NUM_REQ-1:0]    w_upper_mask;
    logic [NUM_REQ-1:0]    w_upper_req;
    logic [NUM_REQ-1:0]    w_pick_vec;
    logic [NUM_REQ-1:0]    w_onehot;
    logic [NUM_REQ-1:0]    w_req_ready;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // Running OR chains used to encode the one-hot winner into an index and
    // to mux its packet without any variable indexing.
    logic [NUM_REQ:0][IDX_W-1:0]      w_idx_acc;
    logic [NUM_REQ:0][DATA_WIDTH-1:0] w_data_acc;

    // ------------------------------------------------------------------------
    // Round-robin selection: prefer the lowest valid index strictly above the
    // last winner; if none, wrap around to the lowest valid index overall.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_upper_mask[gi]  = (IDX_W'(gi) > last_winner_q);
            assign w_idx_acc[gi+1]   = w_idx_acc[gi] | ({IDX_W{w_onehot[gi]}} & IDX_W'(gi));
            assign w_data_acc[gi+1]  = w_data_acc[gi]
                                     | ({DATA_WIDTH{w_onehot[gi]}}
                                        & bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH]);
        end
    endgenerate

    assign w_idx_acc[0]  = '0;
    assign w_data_acc[0] = '0;

    assign w_upper_req = bus.req_valid & w_upper_mask;
    assign w_pick_vec  = (|w_upper_req) ? w_upper_req : bus.req_valid;
    // Isolate the lowest set bit (x & -x).
    assign w_onehot    = w_pick_vec & (~w_pick_vec + NUM_REQ'(1));
    assign w_sel_idx   = w_idx_acc[NUM_REQ];
    assign w_sel_data  = w_data_acc[NUM_REQ];

    // The register can take a packet when empty or when being drained this
    // cycle; reset blocks every grant so nothing is lost into a clearing flop.
    assign w_free      = ~rst & ((state_q == ST_EMPTY) | bus.out_ready);
    assign w_req_ready = w_free ? w_onehot : '0;
    assign w_transfer  = |w_req_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        out_data_d    = out_data_q;
        grant_id_d    = grant_id_q;
        last_winner_d = last_winner_q;
        if (w_transfer) begin
            state_d       = ST_FULL;
            out_data_d    = w_sel_data;
            grant_id_d    = 3'(w_sel_idx);
            last_winner_d = w_sel_idx;
        end else if ((state_q == ST_FULL) && bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            out_data_q    <= '0;
            grant_id_q    <= '0;
            last_winner_q <= C_LAST_RST;
        end else begin
            state_q       <= state_d;
            out_data_q    <= out_data_d;
            grant_id_q    <= grant_id_d;
            last_winner_q <= last_winner_d;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = out_data_q;
    assign bus.grant_id  = grant_id_q;

    // ------------------------------------------------------------------------
    // Optional accepted-packet counter
    // ------------------------------------------------------------------------
`ifdef PORT_ARB_GRANT_CNT_EN
    logic [15:0] grant_count_q, grant_count_d;

    always_comb begin
        grant_count_d = grant_count_q;
        if (w_transfer) begin
            grant_count_d = grant_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count_q <= '0;
        end else begin
            grant_count_q <= grant_count_d;
        end
    end

    assign bus.grant_count = grant_count_q;
`else
    assign bus.grant_count = 16'd0;
`endif

endmodule
`default_nettype wire
